// File: rtl/trivium_keygen.sv
// trivium_keygen: Trivium keystream generator.
// Loads an 80-bit key and an 80-bit IV, runs WARMUP discarded updates and then
// produces WORD_W-bit keystream words on request, one keystream bit per clock.
// The 288-bit state keeps Trivium bit s(i) at st_q[i-1].
module trivium_keygen #(
    parameter int unsigned WARMUP = 1152,
    parameter int unsigned WORD_W = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              reseed,
    input  logic [79:0]       seed,
    input  logic [79:0]       iv,
    input  logic              req,
    output logic [WORD_W-1:0] ks_word,
    output logic              ks_vld,
    output logic              ready,
    output logic              busy
);

    localparam int unsigned WU_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int unsigned BC_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_READY,
        S_GEN
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [287:0]      st_q;
    logic [287:0]      st_load;
    logic [287:0]      st_upd;
    logic              z;
    logic              t1;
    logic              t2;
    logic              t3;
    logic              n1;
    logic              n2;
    logic              n3;

    logic [WU_W-1:0]   wu_cnt_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic              wu_last;
    logic              bit_last;

    logic [WORD_W-1:0] sh_q;
    logic [WORD_W:0]   sh_cat;
    logic [WORD_W-1:0] sh_next;

    assign wu_last  = (wu_cnt_q == WU_W'(WARMUP - 1));
    assign bit_last = (bit_cnt_q == BC_W'(WORD_W - 1));

    assign ready = (state_q == S_READY);
    assign busy  = (state_q == S_WARMUP) || (state_q == S_GEN);

    // Initial state image: key bit-reversed into s1..s80, IV into s94..s173, s286..s288 set.
    always_comb begin
        st_load = '0;
        for (int unsigned i = 0; i < 80; i++) begin
            st_load[i]      = seed[79 - i];
            st_load[93 + i] = iv[79 - i];
        end
        st_load[287:285] = '1;
    end

    // One Trivium update: keystream bit z and the three-register shift.
    always_comb begin
        t1 = st_q[65]  ^ st_q[92];
        t2 = st_q[161] ^ st_q[176];
        t3 = st_q[242] ^ st_q[287];
        z  = t1 ^ t2 ^ t3;
        n1 = t1 ^ (st_q[90]  & st_q[91])  ^ st_q[170];
        n2 = t2 ^ (st_q[174] & st_q[175]) ^ st_q[263];
        n3 = t3 ^ (st_q[285] & st_q[286]) ^ st_q[68];
        st_upd = {st_q[286:177], n2, st_q[175:93], n1, st_q[91:0], n3};
    end

    // Word assembly: new bit enters at the LSB so the first bit ends up in the MSB.
    always_comb begin
        sh_cat  = {sh_q, z};
        sh_next = sh_cat[WORD_W-1:0];
    end

    // Next-state logic; reseed overrides everything except reset.
    always_comb begin
        state_d = state_q;
        if (reseed) begin
            state_d = S_WARMUP;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_IDLE;
                S_WARMUP: if (wu_last) state_d = S_READY;
                S_READY:  if (req) state_d = S_GEN;
                S_GEN:    if (bit_last) state_d = S_READY;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: state register, counters, word shift register and output word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q      <= '0;
            wu_cnt_q  <= '0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            ks_word   <= '0;
            ks_vld    <= 1'b0;
        end else if (reseed) begin
            st_q      <= st_load;
            wu_cnt_q  <= '0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            ks_word   <= '0;
            ks_vld    <= 1'b0;
        end else begin
            ks_vld <= 1'b0;
            case (state_q)
                S_WARMUP: begin
                    st_q     <= st_upd;
                    wu_cnt_q <= wu_cnt_q + 1'b1;
                end
                S_READY: begin
                    if (req) begin
                        bit_cnt_q <= '0;
                    end
                end
                S_GEN: begin
                    st_q      <= st_upd;
                    sh_q      <= sh_next;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_last) begin
                        ks_word <= sh_next;
                        ks_vld  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trivium_keygen.sv
// tb_trivium_keygen: directed bench for trivium_keygen with a queue scoreboard.
// A bit-level Trivium reference (1-based s[1..288]) supplies the expected words.
module tb_trivium_keygen;

    localparam int WARMUP = 1152;
    localparam int WORD_W = 64;

    localparam logic [79:0] KEY_A = 80'h0053A6F94C9FF24598EB;
    localparam logic [79:0] IV_A  = 80'h0D74DB42A91077DE45AC;
    localparam logic [79:0] KEY_B = 80'h9953A6F94C9FF24598EB;

    logic              CLK = 1'b0;
    logic              RST;
    logic              reseed;
    logic [79:0]       seed;
    logic [79:0]       iv;
    logic              req;
    logic [WORD_W-1:0] ks_word;
    logic              ks_vld;
    logic              ready;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0] exp_q [$];
    bit                m [1:288];

    always #5 CLK = ~CLK;

    trivium_keygen #(
        .WARMUP(WARMUP),
        .WORD_W(WORD_W)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .reseed (reseed),
        .seed   (seed),
        .iv     (iv),
        .req    (req),
        .ks_word(ks_word),
        .ks_vld (ks_vld),
        .ready  (ready),
        .busy   (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model
    task automatic m_load(input logic [79:0] k, input logic [79:0] v);
        for (int i = 1; i <= 288; i++) m[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            m[i]      = k[80 - i];
            m[93 + i] = v[80 - i];
        end
        m[286] = 1'b1;
        m[287] = 1'b1;
        m[288] = 1'b1;
    endtask

    task automatic m_step(output bit zo);
        bit a1, a2, a3;
        a1 = m[66] ^ m[93];
        a2 = m[162] ^ m[177];
        a3 = m[243] ^ m[288];
        zo = a1 ^ a2 ^ a3;
        a1 = a1 ^ (m[91] & m[92]) ^ m[171];
        a2 = a2 ^ (m[175] & m[176]) ^ m[264];
        a3 = a3 ^ (m[286] & m[287]) ^ m[69];
        for (int i = 93; i >= 2; i--) m[i] = m[i - 1];
        m[1] = a3;
        for (int i = 177; i >= 95; i--) m[i] = m[i - 1];
        m[94] = a1;
        for (int i = 288; i >= 179; i--) m[i] = m[i - 1];
        m[178] = a2;
    endtask

    task automatic m_warm();
        bit zd;
        for (int i = 0; i < WARMUP; i++) m_step(zd);
    endtask

    task automatic m_word(output logic [WORD_W-1:0] w);
        bit b;
        w = '0;
        for (int i = 0; i < WORD_W; i++) begin
            m_step(b);
            w = {w[WORD_W-2:0], b};
        end
    endtask

    // Monitor: every ks_vld pulse must match the oldest expected word
    always @(negedge CLK) begin
        if (ready === 1'b1 && busy === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_busy_exclusive: got ready=1 busy=1 expected not both");
        end
        if (ks_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ks_vld: got word %h expected no ks_vld", ks_word);
            end else begin
                chk("ks_word", 64'(ks_word), 64'(exp_q.pop_front()));
            end
        end
    end

    // Reseed and wait for ready, checking warm-up latency and busy duration.
    task automatic reseed_and_warm(input logic [79:0] k, input logic [79:0] v,
                                   input bit with_req, input int req_at, input string tag);
        int  cnt;
        int  busy_cnt;
        bit  seen;
        @(negedge CLK);
        seed   = k;
        iv     = v;
        reseed = 1'b1;
        req    = with_req;
        cnt      = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && cnt < WARMUP + 100) begin
            @(negedge CLK);
            reseed = 1'b0;
            req    = 1'b0;
            cnt++;
            if (cnt == 1) begin
                chk({tag, "_word_cleared"}, 64'(ks_word), 64'd0);
                chk({tag, "_vld_low"}, 64'(ks_vld), 64'd0);
            end
            if (ready) seen = 1'b1;
            else if (busy) busy_cnt++;
            if (cnt == req_at) req = 1'b1;
        end
        // ready is first seen after the WARMUPth update edge following the load edge
        chk({tag, "_ready_latency"}, 64'(cnt), 64'(WARMUP + 1));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(WARMUP));
        m_load(k, v);
        m_warm();
    endtask

    // Issue n words back to back; each req after the first is raised while ks_vld is high.
    task automatic request_words(input int n, input string tag);
        logic [WORD_W-1:0] w;
        int cnt;
        bit got;
        for (int i = 0; i < n; i++) begin
            m_word(w);
            exp_q.push_back(w);
        end
        @(negedge CLK);
        req = 1'b1;
        for (int i = 0; i < n; i++) begin
            cnt = 0;
            got = 1'b0;
            while (!got && cnt < 200) begin
                @(negedge CLK);
                req = 1'b0;
                cnt++;
                if (ks_vld) got = 1'b1;
            end
            chk({tag, "_vld_latency"}, 64'(cnt), 64'(WORD_W + 1));
            if (i < n - 1) req = 1'b1;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: got no completion expected finish before 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        RST    = 1'b1;
        reseed = 1'b0;
        req    = 1'b0;
        seed   = '0;
        iv     = '0;
        repeat (3) @(negedge CLK);
        chk("rst_ks_word", 64'(ks_word), 64'd0);
        chk("rst_ks_vld", 64'(ks_vld), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        RST = 1'b0;

        // req in IDLE is ignored
        @(negedge CLK);
        req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        repeat (20) @(negedge CLK);
        chk("idle_req_ready", 64'(ready), 64'd0);
        chk("idle_req_busy", 64'(busy), 64'd0);

        // Key A: req during warm-up ignored, then z1..z64 and z65..z256
        reseed_and_warm(KEY_A, IV_A, 1'b0, 100, "keyA");
        request_words(1, "keyA_w1");
        request_words(3, "keyA_b2b");

        // All-zero key and IV
        reseed_and_warm(80'd0, 80'd0, 1'b0, 0, "zero");
        request_words(1, "zero_w1");

        // Key B with reseed and req together: reseed wins
        reseed_and_warm(KEY_B, IV_A, 1'b1, 0, "keyB");
        request_words(1, "keyB_w1");

        // Abort a word 30 cycles into GEN with a reseed to key A
        @(negedge CLK);
        req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        repeat (28) @(negedge CLK);
        chk("midgen_busy", 64'(busy), 64'd1);
        reseed_and_warm(KEY_A, IV_A, 1'b0, 0, "abort");
        request_words(1, "abort_fresh");

        // RST together with reseed 500 cycles into warm-up
        @(negedge CLK);
        seed   = KEY_A;
        iv     = IV_A;
        reseed = 1'b1;
        @(negedge CLK);
        reseed = 1'b0;
        repeat (499) @(negedge CLK);
        RST    = 1'b1;
        reseed = 1'b1;
        @(negedge CLK);
        RST    = 1'b0;
        reseed = 1'b0;
        chk("rstwu_ks_word", 64'(ks_word), 64'd0);
        chk("rstwu_ks_vld", 64'(ks_vld), 64'd0);
        chk("rstwu_ready", 64'(ready), 64'd0);
        chk("rstwu_busy", 64'(busy), 64'd0);
        req = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        repeat (50) @(negedge CLK);
        chk("rstwu_idle_ready", 64'(ready), 64'd0);
        chk("rstwu_idle_busy", 64'(busy), 64'd0);

        chk("pending_words", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trivium_keygen.md
TRIVIUM_KEYGEN -- requirements
Module: trivium_keygen

Interface
REQ-001 Parameter WARMUP, default 1152, number of initialisation clocks before keystream output (4 x 288).
REQ-002 Parameter WORD_W, default 64, keystream word width in bits (1 bit per clock).
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 reseed  input  1  single-cycle pulse; loads seed/iv and starts warm-up.
REQ-006 seed  input  80  Trivium key; seed[79] = K1 ... seed[0] = K80.
REQ-007 iv  input  80  Trivium IV; iv[79] = IV1 ... iv[0] = IV80.
REQ-008 req  input  1  request one WORD_W keystream word; single-cycle pulse.
REQ-009 ks_word  output  WORD_W  last completed keystream word; first generated bit in ks_word[WORD_W-1].
REQ-010 ks_vld  output  1  one-cycle pulse; ks_word newly valid.
REQ-011 ready  output  1  warm-up complete and idle; req accepted only while high.
REQ-012 busy  output  1  load, warm-up or word generation in progress.

Function
REQ-013 State register: 288 bits s1..s288; FSM states IDLE, WARMUP, READY, GEN.
REQ-014 Load, on the edge sampling reseed=1: s1..s80 = K1..K80, s81..s93 = 0, s94..s173 = IV1..IV80, s174..s285 = 0, s286..s288 = 1; warm-up counter cleared; FSM -> WARMUP.
REQ-015 Per update: t1 = s66^s93, t2 = s162^s177, t3 = s243^s288; z = t1^t2^t3; t1 ^= s91&s92^s171; t2 ^= s175&s176^s264; t3 ^= s286&s287^s69; shift s1..s93 <- (t3, s1..s92), s94..s177 <- (t1, s94..s176), s178..s288 <- (t2, s178..s287).
REQ-016 WARMUP: exactly WARMUP updates on the WARMUP edges following the load edge; z discarded; FSM -> READY on the WARMUPth update edge.
REQ-017 Latency: ready first high in the cycle after the WARMUPth edge following the reseed edge (1152 edges at default).
REQ-018 READY: no state updates; req=1 sampled -> GEN, bit counter cleared, no update on that edge.
REQ-019 GEN: one update per edge for WORD_W edges; z shifted into an internal shift register MSB-first.
REQ-020 On the WORD_Wth GEN edge: ks_word <= completed shift register, ks_vld = 1 for exactly one cycle, FSM -> READY.
REQ-021 ks_word holds its value until the next completed word, reseed or reset.
REQ-022 busy = 1 in WARMUP and GEN; ready = 1 only in READY; never both high.
REQ-023 req while not READY: ignored, not queued, no side effects.
REQ-024 req in the same cycle ks_vld is high: accepted (FSM already READY), next word starts with no gap.
REQ-025 reseed in any state (including mid-WARMUP or mid-GEN): aborts current operation, reloads per REQ-014, ks_word cleared to 0, no ks_vld for the aborted word.
REQ-026 reseed and req in the same cycle: reseed wins, req dropped.
REQ-027 Counters: warm-up counter 11 bits, bit counter 7 bits at default parameters; no wrap-around reachable in normal operation.
REQ-028 Keystream continuity: consecutive words without reseed are contiguous segments of a single Trivium stream.

Reset
REQ-029 RST=1 sampled: FSM -> IDLE; state register, counters, shift register, ks_word = 0; ks_vld, ready, busy = 0.
REQ-030 RST has priority over reseed and req in the same cycle.
REQ-031 IDLE: no updates; leaves only on reseed; req ignored.
REQ-032 RST mid-WARMUP or mid-GEN: all outputs 0 in the following cycle; no partial word output.

Verification
REQ-033 RST, then reseed with seed=80'h0053A6F94C9FF24598EB, iv=80'h0D74DB42A91077DE45AC -> busy=1 for 1152 cycles; ready rises on cycle 1152 after the reseed edge.
REQ-034 After REQ-033, req pulse -> ks_vld one pulse exactly 64 cycles later; ks_word equals the golden-model bits z1..z64; three back-to-back reqs -> z65..z256 contiguous.
REQ-035 seed=0, iv=0 and seed=80'h9953A6F94C9FF24598EB with the same iv -> ks_word matches golden model; words differ from the REQ-034 words.
REQ-036 reseed at cycle 30 of GEN -> no ks_vld; ks_word=0; ready returns 1152 cycles later; next word equals first word of a fresh stream.
REQ-037 req while busy in WARMUP, and req in IDLE after reset -> no ks_vld, no state change.
REQ-038 RST asserted at cycle 500 of WARMUP, together with reseed -> all outputs 0 next cycle, FSM in IDLE, reseed ignored.
